// File: rtl/usb_utmi_pkg.sv
// usb_utmi_pkg: UTMI line-state encoding and receive FSM state type
package usb_utmi_pkg;
   typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_J = 2'b01, LS_K = 2'b10, LS_SE1 = 2'b11} utmi_line_state_t;
   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} usb_rx_state_t;
endpackage

// File: rtl/usb_utm_rx_if.sv
// usb_utm_rx_if: line-side bit stream in, assembled bytes and status out
interface usb_utm_rx_if;
   import usb_utmi_pkg::*;
   utmi_line_state_t line_state;
   logic ls_valid;
   logic dbit;
   logic dbit_valid;
   logic unstuff_error;
   logic [7:0] rx_data;
   logic rx_valid;
   logic rx_active;
   logic rx_error;
   modport master (output line_state, ls_valid, dbit, dbit_valid, unstuff_error,
                   input rx_data, rx_valid, rx_active, rx_error);
   modport slave (input line_state, ls_valid, dbit, dbit_valid, unstuff_error,
                  output rx_data, rx_valid, rx_active, rx_error);
endinterface

// File: rtl/usb_utm_rx.sv
// usb_utm_rx: SYNC/byte/EOP receive FSM after the unstuffer
// USB_UTM_RX_STUFF_ERR_EN: unstuff_error during DATA aborts the packet
module usb_utm_rx
   import usb_utmi_pkg::*;
#(
   parameter int unsigned SYNC_MIN_ZEROS = 5,
   parameter int unsigned EOP_SE0_MIN = 2
) (
   input logic clk,
   input logic rst_n,
   usb_utm_rx_if.slave bus
);
   localparam logic [2:0] SZ = 3'(SYNC_MIN_ZEROS);
   localparam logic [2:0] EM = 3'(EOP_SE0_MIN);
   usb_rx_state_t state;
   logic [2:0] zcnt, bcnt, scnt;
   logic [6:0] sr;
   logic misalign;
   logic se0, stuff_abort;
   assign se0 = bus.ls_valid && bus.line_state == LS_SE0;
`ifdef USB_UTM_RX_STUFF_ERR_EN
   assign stuff_abort = bus.unstuff_error;
`else
   logic stuff_unused;
   assign stuff_abort = 1'b0;
   assign stuff_unused = bus.unstuff_error;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         zcnt <= 3'd0;
         bcnt <= 3'd0;
         scnt <= 3'd0;
         sr <= 7'd0;
         misalign <= 1'b0;
         bus.rx_data <= 8'h00;
         bus.rx_valid <= 1'b0;
         bus.rx_active <= 1'b0;
         bus.rx_error <= 1'b0;
      end else begin
         bus.rx_valid <= 1'b0;
         bus.rx_error <= 1'b0;
         case (state)
            IDLE:
               if (!se0 && bus.dbit_valid && !bus.dbit) begin
                  state <= SYNC;
                  zcnt <= 3'd1;
               end
            SYNC:
               if (se0) begin
                  state <= IDLE;
                  zcnt <= 3'd0;
               end else if (bus.dbit_valid) begin
                  if (!bus.dbit) zcnt <= (zcnt == 3'd7) ? zcnt : zcnt + 3'd1;
                  else begin
                     state <= (zcnt >= SZ) ? DATA : IDLE;
                     bus.rx_active <= zcnt >= SZ;
                     zcnt <= 3'd0;
                     bcnt <= 3'd0;
                  end
               end
            DATA:
               if (se0) begin
                  state <= EOP;
                  scnt <= 3'd1;
                  misalign <= bcnt != 3'd0;
               end else if (stuff_abort) begin
                  state <= ABORT;
                  bus.rx_error <= 1'b1;
                  bus.rx_active <= 1'b0;
               end else if (bus.dbit_valid) begin
                  sr <= {bus.dbit, sr[6:1]};
                  bcnt <= bcnt + 3'd1;
                  if (bcnt == 3'd7) begin
                     bus.rx_data <= {bus.dbit, sr};
                     bus.rx_valid <= 1'b1;
                  end
               end
            EOP:
               if (se0) scnt <= (scnt == 3'd7) ? scnt : scnt + 3'd1;
               else if (bus.ls_valid) begin
                  // a short SE0, K or SE1 all end the packet as an abort
                  bus.rx_active <= 1'b0;
                  state <= (bus.line_state == LS_J && scnt >= EM) ? IDLE : ABORT;
                  bus.rx_error <= (bus.line_state == LS_J && scnt >= EM) ? misalign : 1'b1;
                  scnt <= 3'd0;
                  bcnt <= 3'd0;
                  misalign <= 1'b0;
               end
            ABORT:
               if (bus.ls_valid && bus.line_state == LS_J) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule
